// File: rtl/alu_writeback_stage_pkg.sv
// Shared definitions for the ALU writeback stage: flag bit positions and FIFO entry layout.
// Entry layout (MSB..LSB): {flags_we, rd_we, rd, flags, data}.
// Sticky subset helper: {nan, subnormal, inf, overflow}.
package alu_writeback_stage_pkg;

  // Status flag vector is {nan,subnormal,inf,cout,zero,negative,overflow}
  localparam int FLAGS_W  = 7;
  localparam int FLG_OVF  = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_COUT = 3;
  localparam int FLG_INF  = 4;
  localparam int FLG_SUB  = 5;
  localparam int FLG_NAN  = 6;

  localparam int STICKY_W = 4;

  // Default datapath widths, matching the 16-bit ALU and a 16-entry register file
  localparam int DATA_W_DEF = 16;
  localparam int RD_W_DEF   = 4;

  // Entry field offsets; data occupies [data_w-1:0]
  function automatic int e_flags_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int e_rd_lsb(input int data_w);
    return data_w + FLAGS_W;
  endfunction

  function automatic int e_rd_we_bit(input int data_w, input int rd_w);
    return data_w + FLAGS_W + rd_w;
  endfunction

  function automatic int e_flags_we_bit(input int data_w, input int rd_w);
    return data_w + FLAGS_W + rd_w + 1;
  endfunction

  function automatic int entry_w(input int data_w, input int rd_w);
    return data_w + FLAGS_W + rd_w + 2;
  endfunction

  // Extract the accumulating subset of the flags
  function automatic logic [STICKY_W-1:0] sticky_bits(input logic [FLAGS_W-1:0] f);
    return {f[FLG_NAN], f[FLG_SUB], f[FLG_INF], f[FLG_OVF]};
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count and full/empty flags.
// Latency: a pushed word is visible at rdata_o one edge after the push.
// Backpressure: push while full and pop while empty are ignored internally.
module alu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state pointers and count; pointers wrap naturally as DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards all stored entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful while count covers them, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU result/writeback stage: buffers results in a FIFO, retires to the register file, updates status.
// Latency: one edge from accepted push to wb_valid; no same-cycle bypass.
// Backpressure: in_ready is registered state (full/reset), never combinational from wb_ready.
// Optional feature macro: ALU_WB_STICKY_FLAGS_EN enables the sticky {nan,subnormal,inf,overflow} register.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int RD_W   = RD_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_r,
  input  logic [FLAGS_W-1:0]  in_flags,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_rd_we,
  input  logic                in_flags_we,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [DATA_W-1:0]   wb_data,
  output logic [RD_W-1:0]     wb_rd,
  output logic                wb_we,
  output logic [FLAGS_W-1:0]  status_flags,
  output logic [STICKY_W-1:0] sticky_flags,
  input  logic                sticky_clr
);

  localparam int FLAGS_LSB = e_flags_lsb(DATA_W);
  localparam int RD_LSB    = e_rd_lsb(DATA_W);
  localparam int RD_WE_BIT = e_rd_we_bit(DATA_W, RD_W);
  localparam int F_WE_BIT  = e_flags_we_bit(DATA_W, RD_W);
  localparam int ENTRY_W   = entry_w(DATA_W, RD_W);

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [DATA_W-1:0]  head_data;
  logic [FLAGS_W-1:0] head_flags;
  logic [RD_W-1:0]    head_rd;
  logic               head_rd_we;
  logic               head_flags_we;

  // Holds in_ready low while reset is asserted and until the first edge after release
  logic               ready_arm_q;
  logic [FLAGS_W-1:0] status_q, status_d;

  assign in_entry = {in_flags_we, in_rd_we, in_rd, in_flags, in_r};

  assign head_data     = head[DATA_W-1:0];
  assign head_flags    = head[FLAGS_LSB +: FLAGS_W];
  assign head_rd       = head[RD_LSB +: RD_W];
  assign head_rd_we    = head[RD_WE_BIT];
  assign head_flags_we = head[F_WE_BIT];

  // Ready depends only on registered state: full refuses a push even when a pop coincides
  assign in_ready = ready_arm_q & ~fifo_full;
  assign wb_valid = ~fifo_empty;
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Head fields are forced to zero when nothing is queued so stale storage never leaks out
  assign wb_data = wb_valid ? head_data : '0;
  assign wb_rd   = wb_valid ? head_rd   : '0;
  assign wb_we   = wb_valid & head_rd_we;

  assign status_flags = status_q;

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Arm the input handshake on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_arm_q <= 1'b0;
    else        ready_arm_q <= 1'b1;
  end

  // Architectural flags follow the last retired flag-writing op
  always_comb begin
    status_d = status_q;
    if (pop && head_flags_we) status_d = head_flags;
  end

  // Status register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= status_d;
  end

`ifdef ALU_WB_STICKY_FLAGS_EN
  logic [STICKY_W-1:0] sticky_q, sticky_d;

  // Every retire contributes; a clear wipes only history, not the bits retiring this cycle
  always_comb begin
    sticky_d = sticky_q;
    if (pop)             sticky_d = (sticky_clr ? '0 : sticky_q) | sticky_bits(head_flags);
    else if (sticky_clr) sticky_d = '0;
  end

  // Sticky register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic sticky_clr_unused;

  assign sticky_clr_unused = sticky_clr;
  assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus randomized traffic.
// Reference model is a queue of entries with status/sticky state updated at each edge.
// Works with and without ALU_WB_STICKY_FLAGS_EN.
module tb_alu_writeback_stage;
  import alu_writeback_stage_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_r;
  logic [6:0]  in_flags;
  logic [3:0]  in_rd;
  logic        in_rd_we;
  logic        in_flags_we;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [6:0]  status_flags;
  logic [3:0]  sticky_flags;
  logic        sticky_clr;

  alu_writeback_stage #(.DEPTH(DEPTH), .RD_W(4), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_r         (in_r),
    .in_flags     (in_flags),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .in_flags_we  (in_flags_we),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .status_flags (status_flags),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic [6:0]  f;
    logic [3:0]  rd;
    logic        rd_we;
    logic        f_we;
  } ent_t;

  int   n_checks = 0;
  int   n_fails  = 0;

  ent_t       m_q[$];
  logic [6:0] m_status;
  logic [3:0] m_sticky;
  bit         m_armed;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] acc_bits(input logic [6:0] f);
    return {f[FLG_NAN], f[FLG_SUB], f[FLG_INF], f[FLG_OVF]};
  endfunction

  function automatic ent_t mk(input logic [15:0] r, input logic [6:0] f, input logic [3:0] rd,
                              input logic rd_we, input logic f_we);
    ent_t e;
    e.r = r; e.f = f; e.rd = rd; e.rd_we = rd_we; e.f_we = f_we;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(16'($urandom), 7'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // One clock: drive at entry (just after a rising edge), check at falling edge, update model at rising edge
  task automatic cycle(input ent_t e, input bit v, input bit wr, input bit clr,
                       output bit pushed, output bit popped);
    bit   exp_rdy;
    ent_t h;
    in_valid    = v;
    in_r        = e.r;
    in_flags    = e.f;
    in_rd       = e.rd;
    in_rd_we    = e.rd_we;
    in_flags_we = e.f_we;
    wb_ready    = wr;
    sticky_clr  = clr;
    @(negedge clk);
    exp_rdy = m_armed && (m_q.size() != DEPTH);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("wb_valid", wb_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check_eq("wb_data", wb_data, m_q[0].r);
      check_eq("wb_rd", wb_rd, m_q[0].rd);
      check_eq("wb_we", wb_we, m_q[0].rd_we);
    end else begin
      check_eq("wb_we_idle", wb_we, 0);
    end
    check_eq("status_flags", status_flags, m_status);
    check_eq("sticky_flags", sticky_flags, m_sticky);
    pushed = v && exp_rdy;
    popped = (m_q.size() != 0) && wr;
    @(posedge clk);
    if (popped) begin
      h = m_q.pop_front();
      if (h.f_we) m_status = h.f;
`ifdef ALU_WB_STICKY_FLAGS_EN
      m_sticky = (clr ? 4'b0 : m_sticky) | acc_bits(h.f);
    end else if (clr) begin
      m_sticky = 4'b0;
`endif
    end
    if (pushed) m_q.push_back(e);
    m_armed = 1'b1;
    #1;
  endtask

  // Offer an entry until accepted, holding it stable while refused
  task automatic send(input ent_t e, input bit wr, input bit clr);
    bit pu, po;
    pu = 1'b0;
    for (int k = 0; k < 20 && !pu; k++) cycle(e, 1'b1, wr, clr, pu, po);
    check_eq("send_accepted", pu, 1);
  endtask

  task automatic idle(input bit wr, input bit clr);
    bit pu, po;
    cycle(mk(16'h0, 7'h0, 4'h0, 1'b0, 1'b0), 1'b0, wr, clr, pu, po);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && m_q.size() != 0; k++) idle(1'b1, 1'b0);
    check_eq("drain_empty", wb_valid, 0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_status = 7'h0;
    m_sticky = 4'h0;
    m_armed  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   pu, po;
    ent_t pend;
    bit   have_pend;
    logic [3:0] exp_s;

    rst_n = 1'b0; in_valid = 0; in_r = 0; in_flags = 0; in_rd = 0;
    in_rd_we = 0; in_flags_we = 0; wb_ready = 0; sticky_clr = 0;
    model_reset();
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1'b0, 1'b0);

    // Single op with zero flag
    send(mk(16'h1234, 7'(1 << FLG_ZERO), 4'd3, 1'b1, 1'b1), 1'b1, 1'b0);
    check_eq("t2_valid", wb_valid, 1);
    check_eq("t2_data", wb_data, 16'h1234);
    check_eq("t2_rd", wb_rd, 3);
    idle(1'b1, 1'b0);
    check_eq("t2_status", status_flags, 7'h04);

    // Back-pressure: A, B fill; C held until space opens
    send(mk(16'hAAAA, 7'h0, 4'd1, 1'b1, 1'b0), 1'b0, 1'b0);
    send(mk(16'hBBBB, 7'h0, 4'd2, 1'b1, 1'b0), 1'b0, 1'b0);
    check_eq("t3_full_ready", in_ready, 0);
    cycle(mk(16'hCCCC, 7'h0, 4'd4, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, pu, po);
    check_eq("t3_c_held", pu, 0);
    cycle(mk(16'hCCCC, 7'h0, 4'd4, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, pu, po);
    check_eq("t3_c_refused_at_pop", pu, 0);
    check_eq("t3_ready_after_pop", in_ready, 1);
    cycle(mk(16'hCCCC, 7'h0, 4'd4, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, pu, po);
    check_eq("t3_c_accepted", pu, 1);
    drain();

    // Reset mid-stream with two entries held
    send(mk(16'h5555, 7'h7F, 4'd5, 1'b1, 1'b1), 1'b0, 1'b0);
    send(mk(16'h6666, 7'h7F, 4'd6, 1'b1, 1'b1), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("t1_in_ready", in_ready, 0);
    check_eq("t1_wb_valid", wb_valid, 0);
    check_eq("t1_wb_data", wb_data, 0);
    check_eq("t1_wb_rd", wb_rd, 0);
    check_eq("t1_wb_we", wb_we, 0);
    check_eq("t1_status", status_flags, 0);
    check_eq("t1_sticky", sticky_flags, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1'b1, 1'b0);
    check_eq("t1_ready_after_release", in_ready, 1);
    check_eq("t1_no_stale_valid", wb_valid, 0);

    // Full throughput at count=1
    send(mk(16'h0F00, 7'(1 << FLG_COUT), 4'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(mk(16'h0F01 + 16'(i), 7'(1 << FLG_COUT), 4'(i + 1), 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, pu, po);
      check_eq("t4_push", pu, 1);
      check_eq("t4_pop", po, 1);
    end
    drain();

    // flags_we=0 leaves status untouched
    send(mk(16'h0101, 7'(1 << FLG_NEG), 4'd7, 1'b1, 1'b1), 1'b1, 1'b0);
    send(mk(16'h0202, 7'h7F, 4'd8, 1'b0, 1'b0), 1'b1, 1'b0);
    drain();
    check_eq("t5_status", status_flags, 7'h02);

    // Sticky accumulation and clear-with-pop
    idle(1'b1, 1'b1);
    send(mk(16'h0303, 7'(1 << FLG_NAN), 4'd9, 1'b1, 1'b0), 1'b1, 1'b0);
    send(mk(16'h0404, 7'(1 << FLG_OVF), 4'd10, 1'b1, 1'b0), 1'b1, 1'b0);
    drain();
`ifdef ALU_WB_STICKY_FLAGS_EN
    exp_s = 4'b1001;
`else
    exp_s = 4'b0000;
`endif
    check_eq("t6_sticky_acc", sticky_flags, exp_s);
    send(mk(16'h0505, 7'(1 << FLG_INF), 4'd11, 1'b1, 1'b0), 1'b0, 1'b0);
    idle(1'b1, 1'b1);
`ifdef ALU_WB_STICKY_FLAGS_EN
    exp_s = 4'b0010;
`else
    exp_s = 4'b0000;
`endif
    check_eq("t6_sticky_clr_pop", sticky_flags, exp_s);

    // Randomized traffic; a refused entry is held until accepted
    have_pend = 1'b0;
    pend = rnd_ent();
    for (int i = 0; i < 400; i++) begin
      if (!have_pend && ($urandom % 4 != 0)) begin
        pend = rnd_ent();
        have_pend = 1'b1;
      end
      cycle(pend, have_pend, ($urandom % 3) != 0, ($urandom % 8) == 0, pu, po);
      if (pu) have_pend = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
